// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and state encoding for the nibble-serial multiplier
package mul_pkg;
    localparam int NIB_W     = 4;
    localparam int OP_W      = 8;
    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_mul8_nibble_if.sv
// rtl/seq_mul8_nibble_if.sv - operand/result handshake bundle for seq_mul8_nibble
interface seq_mul8_nibble_if #(
    parameter int ACC_W = mul_pkg::ACC_W_DEF
);
    logic                     in_valid;
    logic                     in_ready;
    logic [mul_pkg::OP_W-1:0] in_a;
    logic [mul_pkg::OP_W-1:0] in_b;
    logic                     in_acc;
    logic                       out_valid;
    logic                       out_ready;
    logic [mul_pkg::PROD_W-1:0] out_p;
    logic [ACC_W-1:0]           out_acc;
    logic                       busy;

    modport master (
        output in_valid, in_a, in_b, in_acc, out_ready,
        input  in_ready, out_valid, out_p, out_acc, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_acc, out_ready,
        output in_ready, out_valid, out_p, out_acc, busy
    );
endinterface

// File: rtl/mul4_unit.sv
// rtl/mul4_unit.sv - combinational 4x4 unsigned multiplier as a sum of shifted AND rows
module mul4_unit
    import mul_pkg::*;
(
    input  logic [NIB_W-1:0]   x_i,
    input  logic [NIB_W-1:0]   y_i,
    output logic [2*NIB_W-1:0] p_o
);
    always_comb begin
        p_o = '0;
        for (int i = 0; i < NIB_W; i++) begin
            p_o = p_o + ((2*NIB_W)'(x_i & {NIB_W{y_i[i]}}) << i);
        end
    end
endmodule

// File: rtl/seq_mul8_nibble.sv
// rtl/seq_mul8_nibble.sv - sequential 8x8 multiplier, one nibble partial product per cycle, optional accumulate
module seq_mul8_nibble
    import mul_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    seq_mul8_nibble_if.slave bus
);
    state_t              state_q;
    logic [1:0]          step_q;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                acc_en_q;
    logic [PROD_W-1:0]   psum_q;
    logic [PROD_W-1:0]   psum_d;
    logic [PROD_W-1:0]   out_p_q;
    logic [ACC_W-1:0]    out_acc_q;
    logic [ACC_W-1:0]    acc_d;
    logic                out_valid_q;
    logic [NIB_W-1:0]    x_nib;
    logic [NIB_W-1:0]    y_nib;
    logic [2*NIB_W-1:0]  pp;
    logic                accept;

    // step[1] picks the a nibble, step[0] the b nibble
    assign x_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
    assign y_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

    mul4_unit u_mul4 (
        .x_i (x_nib),
        .y_i (y_nib),
        .p_o (pp)
    );

    always_comb begin
        psum_d = psum_q;
        case (step_q)
            2'd0:    psum_d = psum_q + PROD_W'(pp);
            2'd3:    psum_d = psum_q + (PROD_W'(pp) << 8);
            default: psum_d = psum_q + (PROD_W'(pp) << 4);
        endcase
    end

    assign acc_d  = acc_en_q ? (out_acc_q + ACC_W'(psum_d)) : ACC_W'(psum_d);
    assign accept = bus.in_valid & bus.in_ready;

    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= 2'd0;
            a_q         <= '0;
            b_q         <= '0;
            acc_en_q    <= 1'b0;
            psum_q      <= '0;
            out_p_q     <= '0;
            out_acc_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            // also covers retiring a DONE result on the same edge
            state_q     <= MUL;
            step_q      <= 2'd0;
            a_q         <= bus.in_a;
            b_q         <= bus.in_b;
            acc_en_q    <= bus.in_acc;
            psum_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                MUL: begin
                    psum_q <= psum_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        out_p_q     <= psum_d;
                        out_acc_q   <= acc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul8_nibble.sv
// tb/tb_seq_mul8_nibble.sv - randomized self-checking bench for seq_mul8_nibble against an arithmetic model
module tb_seq_mul8_nibble;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    longint m_acc;
    longint m_acc16;

    seq_mul8_nibble_if #(.ACC_W(20)) bus ();
    seq_mul8_nibble_if #(.ACC_W(16)) bus16 ();

    seq_mul8_nibble #(.ACC_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_mul8_nibble #(.ACC_W(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts and ends just after a falling edge; k = rising edges from accept to out_valid.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                          output int k, output int rdy_seen, output int busy_low);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        rdy_seen = 0;
        busy_low = 0;
        while (k < 20 && bus.out_valid !== 1'b1) begin
            if (bus.in_ready !== 1'b0) rdy_seen++;
            if (bus.busy !== 1'b1) busy_low++;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        if (acc) m_acc = (m_acc + longint'(a) * longint'(b)) & 64'hF_FFFF;
        else     m_acc = longint'(a) * longint'(b);
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_p !== 16'h0 || bus.out_acc !== 20'h0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b p=%h acc=%h rdy=%b busy=%b, expected 0 0 0 1 0",
                     bus.out_valid, bus.out_p, bus.out_acc, bus.in_ready, bus.busy);
        end
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.out_acc !== 16'h0 || bus16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset16: valid=%b acc=%h rdy=%b, expected 0 0 1",
                     bus16.out_valid, bus16.out_acc, bus16.in_ready);
        end
    endtask

    task automatic test_ffxff();
        int k, rs, bl;
        bus.out_ready = 1'b1;
        run_op(8'hFF, 8'hFF, 1'b0, k, rs, bl);
        checks++;
        if (k !== 4) begin
            errors++;
            $display("FAIL ffxff_latency: got %0d edges, expected 4", k);
        end
        checks++;
        if (rs !== 0 || bl !== 0) begin
            errors++;
            $display("FAIL ffxff_mul_flags: in_ready high %0d, busy low %0d cycles, expected 0 0", rs, bl);
        end
        checks++;
        if (bus.out_p !== 16'hFE01 || bus.out_acc !== 20'h0FE01) begin
            errors++;
            $display("FAIL ffxff_result: p=%h acc=%h, expected fe01 0fe01", bus.out_p, bus.out_acc);
        end
        retire();
    endtask

    task automatic test_sequence();
        logic [7:0] av [3] = '{8'h12, 8'h03, 8'hFF};
        logic [7:0] bv [3] = '{8'h34, 8'h05, 8'hFF};
        logic       cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] a, b;
        logic       c;
        int k, rs, bl;
        longint exp_p;
        for (int i = 0; i < 19; i++) begin
            if (i < 3) begin
                a = av[i]; b = bv[i]; c = cv[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            end
            exp_p = longint'(a) * longint'(b);
            run_op(a, b, c, k, rs, bl);
            checks++;
            if (k !== 4 || bus.out_p !== exp_p[15:0] || bus.out_acc !== m_acc[19:0]) begin
                errors++;
                $display("FAIL seq_op%0d: %h*%h acc=%b got k=%0d p=%h acc=%h, expected k=4 p=%h acc=%h",
                         i, a, b, c, k, bus.out_p, bus.out_acc, exp_p[15:0], m_acc[19:0]);
            end
            retire();
        end
    endtask

    task automatic test_hold();
        int k, rs, bl;
        longint exp_p;
        bus.out_ready = 1'b0;
        exp_p = 64'h9C * 64'h3B;
        run_op(8'h9C, 8'h3B, 1'b1, k, rs, bl);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'($urandom);
            bus.in_b     = 8'($urandom);
            bus.in_acc   = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_p !== exp_p[15:0] ||
                bus.out_acc !== m_acc[19:0] || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cyc%0d: valid=%b p=%h acc=%h rdy=%b, expected 1 %h %h 0",
                         i, bus.out_valid, bus.out_p, bus.out_acc, bus.in_ready,
                         exp_p[15:0], m_acc[19:0]);
            end
        end
        retire();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out_acc !== m_acc[19:0]) begin
            errors++;
            $display("FAIL hold_retire: valid=%b busy=%b acc=%h, expected 0 0 %h",
                     bus.out_valid, bus.busy, bus.out_acc, m_acc[19:0]);
        end
    endtask

    task automatic test_mid_reset();
        int k, rs, bl;
        int seen;
        bus.out_ready = 1'b1;
        bus.in_a = 8'hAB; bus.in_b = 8'hCD; bus.in_acc = 1'b1; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        m_acc = 0;
        m_acc16 = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_p !== 16'h0 || bus.out_acc !== 20'h0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_values: valid=%b p=%h acc=%h rdy=%b busy=%b, expected 0 0 0 1 0",
                     bus.out_valid, bus.out_p, bus.out_acc, bus.in_ready, bus.busy);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: activity on %0d cycles, expected 0", seen);
        end
        run_op(8'h02, 8'h03, 1'b1, k, rs, bl);
        checks++;
        if (k !== 4 || bus.out_p !== 16'h0006 || bus.out_acc !== m_acc[19:0]) begin
            errors++;
            $display("FAIL midrst_next: k=%0d p=%h acc=%h, expected k=4 p=0006 acc=%h",
                     k, bus.out_p, bus.out_acc, m_acc[19:0]);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        int pulses, last, c;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_acc = 0;
        bus.out_ready = 1'b1;
        bus.in_a = 8'h10; bus.in_b = 8'h10; bus.in_acc = 1'b1; bus.in_valid = 1'b1;
        pulses = 0;
        last = 0;
        c = 0;
        while (c < 40 && pulses < 3) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            if (bus.out_valid === 1'b1) begin
                m_acc = (m_acc + 64'h100) & 64'hF_FFFF;
                pulses++;
                checks++;
                if (c - last !== 5 || bus.out_p !== 16'h0100 || bus.out_acc !== m_acc[19:0]) begin
                    errors++;
                    $display("FAIL b2b_pulse%0d: gap=%0d p=%h acc=%h, expected gap=5 p=0100 acc=%h",
                             pulses, c - last, bus.out_p, bus.out_acc, m_acc[19:0]);
                end
                last = c;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (pulses !== 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d pulses, expected 3", pulses);
        end
        retire();
    endtask

    task automatic test_acc16();
        logic [7:0] a, b;
        int k;
        longint exp_p;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = (i < 2) ? 8'hFF : 8'($urandom);
            b = (i < 2) ? 8'hFF : 8'($urandom);
            exp_p = longint'(a) * longint'(b);
            m_acc16 = (m_acc16 + exp_p) & 64'hFFFF;
            bus16.in_a = a; bus16.in_b = b; bus16.in_acc = 1'b1; bus16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus16.in_valid = 1'b0;
            k = 0;
            while (k < 20 && bus16.out_valid !== 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                k++;
            end
            checks++;
            if (k !== 4 || bus16.out_p !== exp_p[15:0] || bus16.out_acc !== m_acc16[15:0]) begin
                errors++;
                $display("FAIL acc16_op%0d: k=%0d p=%h acc=%h, expected k=4 p=%h acc=%h",
                         i, k, bus16.out_p, bus16.out_acc, exp_p[15:0], m_acc16[15:0]);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_acc = 0;
        m_acc16 = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_acc = 1'b0; bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_acc = 1'b0; bus16.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_ffxff();
        test_sequence();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        test_acc16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_mul8_nibble.md
Name: seq_mul8_nibble

Overview:
- Sequential 8x8 unsigned multiplier, optionally accumulating, built around the team's combinational 4x4 multiplier.
- Splits each operand into nibbles and drives one 4x4 partial product per cycle.
- Shifts and sums the four partial products into a 16-bit result, then optionally adds it into a running accumulator.
- Sits directly upstream of the 4x4 multiplier, which it feeds; its valid/ready output goes to downstream datapath logic.

Parameters:
ACC_W, 20, accumulator width in bits; legal range 16..32; accumulator wraps modulo 2^ACC_W.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands this cycle
in_a  input  8  multiplicand, unsigned
in_b  input  8  multiplier, unsigned
in_acc  input  1  sampled with operands; 1 = add product to accumulator, 0 = overwrite accumulator with product
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
out_p  output  16  product in_a*in_b
out_acc  output  ACC_W  accumulator value after this operation
busy  output  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state = IDLE, step = 0, partial-sum = 0, out_p = 0, out_acc = 0, out_valid = 0, busy = 0, in_ready = 1.
- States:
  - IDLE: waiting for operands.
  - MUL: step counter 0..3.
  - DONE: result presented.
- in_ready = (state == IDLE) | (state == DONE & out_ready).
- Accept: in_valid & in_ready at a rising edge.
  - Latch in_a, in_b and in_acc.
  - Clear partial-sum.
  - Go to MUL with step = 0.
- MUL, one partial product per cycle into the 4x4 unit; each zero-extended and added to the 16-bit partial-sum:
  - step 0: a[3:0]*b[3:0], shift 0.
  - step 1: a[3:0]*b[7:4], shift 4.
  - step 2: a[7:4]*b[3:0], shift 4.
  - step 3: a[7:4]*b[7:4], shift 8.
- The sum never exceeds 0xFE01, so no 16-bit overflow is possible.
- Edge completing step 3:
  - out_p <= final sum.
  - out_acc <= latched in_acc ? (out_acc + zero-extended sum) mod 2^ACC_W : zero-extended sum.
  - out_valid <= 1.
  - state <= DONE.
- Latency: accept edge E0; steps at edges E1..E4; out_valid is high in the cycle after E4.
- Zero operands still take 4 MUL cycles; there is no early-out.
- DONE behaviour:
  - out_valid, out_p and out_acc hold stable while out_ready = 0.
  - out_ready & in_valid: result retired and new operands accepted on the same edge; go directly to MUL step 0.
  - out_ready & !in_valid: go to IDLE and clear out_valid.
  - out_acc keeps its value in IDLE.
- Throughput: one result per 5 cycles under continuous valid/ready.
- in_valid during MUL: ignored, since in_ready = 0. The source must hold it; no operand is lost or sampled.
- rst asserted mid-operation: immediate return to reset values. The partial result is discarded and no out_valid is generated.
- in_acc = 0 on the first operation after reset is not required, because the accumulator resets to 0.

Decomposition:
- Shared package (mul_pkg):
  - State encoding constants IDLE/MUL/DONE.
  - NIB_W = 4, OP_W = 8, PROD_W = 16.
  - Default ACC_W.
- One sub-module, mul4_unit: combinational 4x4 unsigned multiplier, o[7:0] = x*y.
  - The team's existing partial-product-tree multiplier, instantiated once.
  - Operand nibbles are selected by a 2-bit step mux.
- Shifter, adder and FSM live in seq_mul8_nibble.

Test Plan:
- Reset, then in_a=0xFF, in_b=0xFF, in_acc=0 with out_ready=1 -> out_valid in the cycle after E4; out_p=0xFE01, out_acc=0x0FE01; in_ready low for the four MUL cycles.
- in_a=0x12, in_b=0x34, in_acc=0, then 0x03*0x05 with in_acc=1, then 0xFF*0xFF with in_acc=1 -> out_p 0x03A8, 0x000F, 0xFE01; out_acc 0x003A8, 0x003B7, 0x101B8.
- Complete a result, hold out_ready=0 for 10 cycles -> out_valid, out_p, out_acc stable; in_valid ignored; in_ready=0 throughout.
- Continuous in_valid=1, out_ready=1 with 0x10*0x10 repeated, in_acc=1 -> out_valid pulses every 5th cycle; out_p=0x0100; out_acc 0x00100, 0x00200, 0x00300.
- Assert rst during MUL step 2 of 0xAB*0xCD -> all outputs return to reset values; no out_valid; a following 0x02*0x03 yields out_p=0x0006.
- ACC_W=16: two accumulating 0xFF*0xFF operations -> out_acc 0xFE01 then 0xFC02, wrapped modulo 2^16.
